// File: rtl/dma_copy_engine.sv
// dma_copy_engine: word-granular block-copy master for the openMSP430 DMA
// slave port. Each word is one read access followed by one write access.
// Bus errors and abort requests end the copy at a word boundary; completion
// is reported by a single-cycle done pulse with sticky status flags.
//
// Bus handshake: the engine raises dma_en together with dma_addr, dma_we and
// dma_din, and holds all of them unchanged until a cycle in which dma_ready
// is high; that cycle is the acceptance. dma_dout and dma_resp are sampled
// exactly one cycle after acceptance, when dma_en is already low again. An
// issued request is never withdrawn except by puc_rst.
module dma_copy_engine #(
    parameter int   LEN_W    = 8,
    parameter logic PRIORITY = 1'b0
) (
    input  logic             mclk,
    input  logic             puc_rst,
    input  logic             start,
    input  logic [15:0]      src_addr,
    input  logic [15:0]      dst_addr,
    input  logic [LEN_W-1:0] len,
    input  logic             abort,
    output logic [14:0]      dma_addr,
    output logic [15:0]      dma_din,
    output logic             dma_en,
    output logic [1:0]       dma_we,
    output logic             dma_priority,
    output logic             dma_wkup,
    input  logic             dma_ready,
    input  logic [15:0]      dma_dout,
    input  logic             dma_resp,
    output logic             busy,
    output logic             done,
    output logic             error,
    output logic             aborted,
    output logic [LEN_W-1:0] words_done
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_RD_REQ = 3'd1,
        S_RD_RSP = 3'd2,
        S_WR_REQ = 3'd3,
        S_WR_RSP = 3'd4,
        S_FIN    = 3'd5
    } state_t;

    state_t state_q;
    state_t state_d;

    // Addresses are kept as word addresses; the byte-address LSB never
    // reaches the bus, and a 15-bit increment wraps 0xFFFE to 0x0000.
    logic [14:0]      cur_src_q;
    logic [14:0]      cur_dst_q;
    logic [15:0]      buf_q;
    logic [LEN_W-1:0] len_q;
    logic [LEN_W-1:0] words_q;
    logic             error_q;
    logic             aborted_q;
    logic             abort_lat_q;

    // Control strobes produced by the next-state logic.
    logic             load;
    logic             capture;
    logic             word_ok;
    logic             set_error;
    logic             set_aborted;

    // Count of completed writes including the one finishing right now;
    // one bit wider so the comparison with len never overflows.
    logic [LEN_W:0]   words_inc;

    // Byte-address LSBs are deliberately ignored.
    logic             unused_addr_lsb;
    assign unused_addr_lsb = src_addr[0] ^ dst_addr[0];

    assign words_inc = {1'b0, words_q} + {{LEN_W{1'b0}}, 1'b1};

    // State register.
    always_ff @(posedge mclk or posedge puc_rst) begin
        if (puc_rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic and datapath strobes.
    always_comb begin
        state_d     = state_q;
        load        = 1'b0;
        capture     = 1'b0;
        word_ok     = 1'b0;
        set_error   = 1'b0;
        set_aborted = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    load = 1'b1;
                    if (len == '0) begin
                        state_d = S_FIN;
                    end else begin
                        state_d = S_RD_REQ;
                    end
                end
            end
            S_RD_REQ: begin
                if (dma_ready) begin
                    state_d = S_RD_RSP;
                end
            end
            S_RD_RSP: begin
                capture = 1'b1;
                if (dma_resp) begin
                    set_error = 1'b1;
                    state_d   = S_FIN;
                end else if (abort_lat_q) begin
                    set_aborted = 1'b1;
                    state_d     = S_FIN;
                end else begin
                    state_d = S_WR_REQ;
                end
            end
            S_WR_REQ: begin
                if (dma_ready) begin
                    state_d = S_WR_RSP;
                end
            end
            S_WR_RSP: begin
                if (dma_resp) begin
                    // A failed write does not count as a completed word.
                    set_error = 1'b1;
                    state_d   = S_FIN;
                end else begin
                    word_ok = 1'b1;
                    // Completion wins over a pending abort on the last word.
                    if (words_inc == {1'b0, len_q}) begin
                        state_d = S_FIN;
                    end else if (abort_lat_q) begin
                        set_aborted = 1'b1;
                        state_d     = S_FIN;
                    end else begin
                        state_d = S_RD_REQ;
                    end
                end
            end
            S_FIN: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Transfer parameters: latched on an accepted start, advanced per word.
    always_ff @(posedge mclk or posedge puc_rst) begin
        if (puc_rst) begin
            cur_src_q <= '0;
            cur_dst_q <= '0;
            len_q     <= '0;
        end else if (load) begin
            cur_src_q <= src_addr[15:1];
            cur_dst_q <= dst_addr[15:1];
            len_q     <= len;
        end else if (word_ok) begin
            cur_src_q <= cur_src_q + 15'd1;
            cur_dst_q <= cur_dst_q + 15'd1;
        end
    end

    // Read data buffer, filled in the read response cycle.
    always_ff @(posedge mclk or posedge puc_rst) begin
        if (puc_rst) begin
            buf_q <= '0;
        end else if (capture) begin
            buf_q <= dma_dout;
        end
    end

    // Progress counter and sticky status, cleared by an accepted start.
    always_ff @(posedge mclk or posedge puc_rst) begin
        if (puc_rst) begin
            words_q   <= '0;
            error_q   <= 1'b0;
            aborted_q <= 1'b0;
        end else if (load) begin
            words_q   <= '0;
            error_q   <= 1'b0;
            aborted_q <= 1'b0;
        end else begin
            if (word_ok) begin
                words_q <= words_inc[LEN_W-1:0];
            end
            if (set_error) begin
                error_q <= 1'b1;
            end
            if (set_aborted) begin
                aborted_q <= 1'b1;
            end
        end
    end

    // Abort latch: remembers an abort request until the next word boundary.
    always_ff @(posedge mclk or posedge puc_rst) begin
        if (puc_rst) begin
            abort_lat_q <= 1'b0;
        end else if (load) begin
            abort_lat_q <= 1'b0;
        end else if (abort && (state_q != S_IDLE)) begin
            abort_lat_q <= 1'b1;
        end
    end

    // Bus outputs decoded from the state so reset drops them at once.
    always_comb begin
        dma_en   = 1'b0;
        dma_we   = 2'b00;
        dma_addr = '0;
        dma_din  = '0;
        case (state_q)
            S_RD_REQ: begin
                dma_en   = 1'b1;
                dma_addr = cur_src_q;
            end
            S_WR_REQ: begin
                dma_en   = 1'b1;
                dma_we   = 2'b11;
                dma_addr = cur_dst_q;
                dma_din  = buf_q;
            end
            default: begin
                dma_en = 1'b0;
            end
        endcase
    end

    assign dma_priority = PRIORITY;
    assign dma_wkup     = dma_en;
    assign busy         = (state_q != S_IDLE);
    assign done         = (state_q == S_FIN);
    assign error        = error_q;
    assign aborted      = aborted_q;
    assign words_done   = words_q;

endmodule

// File: tb/tb_dma_copy_engine.sv
// tb_dma_copy_engine: directed and randomized copies against a word-memory
// slave model; expected bus traffic, cycle counts and status come from a
// reference model built from the copy rules.
module tb_dma_copy_engine;

  localparam int   LEN_W = 8;
  localparam logic PRIO  = 1'b1;

  // clock / reset
  logic mclk = 1'b0;
  logic puc_rst;
  always #5 mclk = ~mclk;

  logic             start;
  logic [15:0]      src_addr;
  logic [15:0]      dst_addr;
  logic [LEN_W-1:0] len;
  logic             abort;
  logic [14:0]      dma_addr;
  logic [15:0]      dma_din;
  logic             dma_en;
  logic [1:0]       dma_we;
  logic             dma_priority;
  logic             dma_wkup;
  logic             dma_ready;
  logic [15:0]      dma_dout;
  logic             dma_resp;
  logic             busy;
  logic             done;
  logic             error;
  logic             aborted;
  logic [LEN_W-1:0] words_done;

  dma_copy_engine #(.LEN_W(LEN_W), .PRIORITY(PRIO)) dut (
    .mclk(mclk), .puc_rst(puc_rst), .start(start), .src_addr(src_addr),
    .dst_addr(dst_addr), .len(len), .abort(abort), .dma_addr(dma_addr),
    .dma_din(dma_din), .dma_en(dma_en), .dma_we(dma_we),
    .dma_priority(dma_priority), .dma_wkup(dma_wkup), .dma_ready(dma_ready),
    .dma_dout(dma_dout), .dma_resp(dma_resp), .busy(busy), .done(done),
    .error(error), .aborted(aborted), .words_done(words_done)
  );

  int n_vec  = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // memories: mem is the slave's storage, ref_mem the model's view
  logic [15:0] mem     [0:32767];
  logic [15:0] ref_mem [0:32767];

  // slave configuration and statistics
  int cfg_wmin = 0, cfg_wmax = 0, cfg_err_rd = 0, cfg_err_wr = 0, cfg_ab_wr = 0;
  int n_rd = 0, n_wr = 0, waits_total = 0, en_cycles = 0;

  // scoreboard: {word addr, we, din} per accepted access
  logic [32:0] log_q[$];
  logic [32:0] exp_q[$];

  // bus slave: decides ready at each negedge, answers one cycle after acceptance
  initial begin : slave
    logic        in_req;
    logic        pend;
    logic        pend_resp;
    logic [15:0] pend_dout;
    logic [14:0] req_addr;
    logic [1:0]  req_we;
    logic [15:0] req_din;
    int          wait_left;
    in_req = 1'b0; pend = 1'b0; pend_resp = 1'b0; pend_dout = '0;
    req_addr = '0; req_we = '0; req_din = '0; wait_left = 0;
    dma_ready = 1'b0; dma_dout = '0; dma_resp = 1'b0; abort = 1'b0;
    forever begin
      @(negedge mclk);
      if (puc_rst) begin
        in_req = 1'b0; pend = 1'b0; wait_left = 0;
        dma_ready = 1'b0; dma_resp = 1'b0; abort = 1'b0;
      end else begin
        if (pend) begin
          dma_dout = pend_dout; dma_resp = pend_resp; pend = 1'b0;
        end else begin
          dma_dout = 16'($urandom); dma_resp = 1'b0;
        end
        abort = 1'b0;
        if (dma_en) begin
          en_cycles++;
          check("wkup", 64'(dma_wkup), 64'(1'b1));
          if (!in_req) begin
            in_req = 1'b1;
            wait_left = int'($urandom_range(cfg_wmax, cfg_wmin));
            req_addr = dma_addr; req_we = dma_we; req_din = dma_din;
          end else begin
            check("hold_addr", 64'(dma_addr), 64'(req_addr));
            check("hold_we", 64'(dma_we), 64'(req_we));
            check("hold_din", 64'(dma_din), 64'(req_din));
          end
          if (dma_we == 2'b11 && n_wr + 1 == cfg_ab_wr) abort = 1'b1;
          if (wait_left > 0) begin
            dma_ready = 1'b0; wait_left--; waits_total++;
          end else begin
            dma_ready = 1'b1; in_req = 1'b0; pend = 1'b1;
            log_q.push_back({dma_addr, dma_we, dma_din});
            if (dma_we == 2'b11) begin
              n_wr++;
              pend_resp = (n_wr == cfg_err_wr);
              pend_dout = 16'($urandom);
              if (!pend_resp) mem[dma_addr] = dma_din;
            end else begin
              n_rd++;
              pend_resp = (n_rd == cfg_err_rd);
              pend_dout = mem[dma_addr];
            end
          end
        end else begin
          dma_ready = 1'b0; in_req = 1'b0;
        end
      end
    end
  end

  // one copy: drive start, wait for done (bounded), compare against the model
  task automatic run_copy(input logic [15:0] s, input logic [15:0] d, input int n,
                          input int wmin, input int wmax, input int err_rd,
                          input int err_wr, input int ab_wr, input int restart_at);
    int exp_rd, exp_wr, exp_wd, wr_err_idx, cyc, done_cyc;
    logic exp_err, exp_ab;
    logic [15:0] v, sa, da;
    @(negedge mclk);
    cfg_wmin = wmin; cfg_wmax = wmax; cfg_err_rd = err_rd; cfg_err_wr = err_wr; cfg_ab_wr = ab_wr;
    n_rd = 0; n_wr = 0; waits_total = 0; en_cycles = 0;
    log_q.delete(); exp_q.delete();
    src_addr = s; dst_addr = d; len = LEN_W'(n); start = 1'b1;
    @(negedge mclk);
    start = 1'b0; cyc = 1; done_cyc = 0;
    check("busy_rise", 64'(busy), 64'(1'b1));
    check("first_en", 64'(dma_en), 64'(n > 0));
    while (done_cyc == 0 && cyc < 3000) begin
      if (cyc == restart_at) begin
        start = 1'b1; src_addr = s ^ 16'h5a5a; dst_addr = d ^ 16'h0f0e; len = LEN_W'(n + 3);
      end
      if (done === 1'b1) done_cyc = cyc;
      else begin
        @(negedge mclk);
        start = 1'b0; cyc++;
      end
    end
    start = 1'b0;
    if (done_cyc == 0) check("done_timeout", 64'(0), 64'(1));

    // reference model: outcome from the copy rules, traffic word by word
    exp_rd = n; exp_wr = n; exp_wd = n; exp_err = 1'b0; exp_ab = 1'b0; wr_err_idx = -1;
    if (err_rd >= 1 && err_rd <= n) begin
      exp_rd = err_rd; exp_wr = err_rd - 1; exp_wd = err_rd - 1; exp_err = 1'b1;
    end else if (err_wr >= 1 && err_wr <= n) begin
      exp_rd = err_wr; exp_wr = err_wr; exp_wd = err_wr - 1; exp_err = 1'b1; wr_err_idx = err_wr - 1;
    end else if (ab_wr >= 1 && ab_wr < n) begin
      exp_rd = ab_wr; exp_wr = ab_wr; exp_wd = ab_wr; exp_ab = 1'b1;
    end
    for (int i = 0; i < exp_rd; i++) begin
      sa = s + 16'(2 * i);
      da = d + 16'(2 * i);
      v = ref_mem[sa[15:1]];
      exp_q.push_back({sa[15:1], 2'b00, 16'h0000});
      if (i < exp_wr) begin
        exp_q.push_back({da[15:1], 2'b11, v});
        if (i != wr_err_idx) ref_mem[da[15:1]] = v;
      end
    end

    check("done_cycle", 64'(done_cyc), 64'(2 * (exp_rd + exp_wr) + waits_total + 1));
    check("error", 64'(error), 64'(exp_err));
    check("aborted", 64'(aborted), 64'(exp_ab));
    check("words_done", 64'(words_done), 64'(exp_wd));
    @(negedge mclk);
    check("done_pulse", 64'(done), 64'(1'b0));
    check("busy_fall", 64'(busy), 64'(1'b0));
    @(negedge mclk);
    @(negedge mclk);
    check("en_cycles", 64'(en_cycles), 64'(exp_rd + exp_wr + waits_total));
    check("error_hold", 64'(error), 64'(exp_err));
    check("access_count", 64'(log_q.size()), 64'(exp_q.size()));
    while (exp_q.size() > 0 && log_q.size() > 0)
      check("access", 64'(log_q.pop_front()), 64'(exp_q.pop_front()));
  endtask

  initial begin : main
    logic [15:0] r;
    logic [15:0] rs, rd;
    int rn;
    puc_rst = 1'b1; start = 1'b0; src_addr = '0; dst_addr = '0; len = '0;
    for (int i = 0; i < 32768; i++) begin
      r = 16'($urandom);
      mem[i] = r; ref_mem[i] = r;
    end
    mem[16'h0100] = 16'h1111; ref_mem[16'h0100] = 16'h1111;
    mem[16'h0101] = 16'h2222; ref_mem[16'h0101] = 16'h2222;
    mem[16'h0102] = 16'h3333; ref_mem[16'h0102] = 16'h3333;

    // reset values
    @(negedge mclk); @(negedge mclk);
    check("rst_en", 64'(dma_en), 64'(1'b0));
    check("rst_addr", 64'(dma_addr), 64'(0));
    check("rst_din", 64'(dma_din), 64'(0));
    check("rst_we", 64'(dma_we), 64'(0));
    check("rst_prio", 64'(dma_priority), 64'(PRIO));
    check("rst_busy", 64'(busy), 64'(1'b0));
    check("rst_done", 64'(done), 64'(1'b0));
    check("rst_flags", 64'({error, aborted}), 64'(0));
    check("rst_words", 64'(words_done), 64'(0));
    puc_rst = 1'b0;

    run_copy(16'h0200, 16'h0300, 3, 0, 0, 0, 0, 0, -1);  // zero-wait, done at 13
    run_copy(16'h0210, 16'h0310, 2, 2, 2, 0, 0, 0, -1);  // 2 wait states, done at 17
    run_copy(16'h0400, 16'h0500, 3, 0, 0, 2, 0, 0, -1);  // error on second read
    run_copy(16'h0600, 16'h0700, 4, 0, 0, 0, 0, 1, -1);  // abort in first write
    run_copy(16'hFFFE, 16'h0800, 2, 0, 0, 0, 0, 0, -1);  // source wrap
    run_copy(16'h0900, 16'h0A00, 0, 0, 0, 0, 0, 0, -1);  // len 0
    run_copy(16'h0B00, 16'h0C00, 3, 0, 1, 0, 0, 0, 3);   // start while busy
    run_copy(16'h0D01, 16'h0E01, 3, 0, 0, 0, 2, 0, -1);  // error on second write
    run_copy(16'h0F00, 16'h1000, 2, 0, 0, 0, 0, 2, -1);  // abort on last word ignored

    // reset during RD_REQ with the slave stalling
    @(negedge mclk);
    cfg_wmin = 8; cfg_wmax = 8; cfg_err_rd = 0; cfg_err_wr = 0; cfg_ab_wr = 0;
    src_addr = 16'h1100; dst_addr = 16'h1200; len = 8'd3; start = 1'b1;
    @(negedge mclk);
    start = 1'b0;
    @(negedge mclk);
    check("rdreq_en", 64'(dma_en), 64'(1'b1));
    #2 puc_rst = 1'b1;
    #1;
    check("midrst_en", 64'(dma_en), 64'(1'b0));
    check("midrst_busy", 64'(busy), 64'(1'b0));
    check("midrst_done", 64'(done), 64'(1'b0));
    @(negedge mclk);
    check("midrst_hold_en", 64'(dma_en), 64'(1'b0));
    puc_rst = 1'b0;
    @(negedge mclk);
    check("postrst_idle", 64'({dma_en, done, busy}), 64'(0));
    run_copy(16'h1300, 16'h1400, 3, 0, 0, 0, 0, 0, -1);  // clean transfer after reset

    // randomized copies, possibly overlapping, with random stalls and aborts
    for (int k = 0; k < 10; k++) begin
      rs = 16'($urandom);
      rd = 16'($urandom);
      rn = int'($urandom_range(12, 1));
      run_copy(rs, rd, rn, 0, int'($urandom_range(3, 0)), 0, 0,
               (k % 2 == 1) ? int'($urandom_range(rn, 1)) : 0, -1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
